// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: per-port forwarding select, load-use and multdiv
// scoreboard stalls, and a fixed-latency multdiv sequencer with writeback slot.
module hazard_ctrl #(
  parameter int NRP    = 3,
  parameter int RW     = 5,
  parameter int MD_LAT = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [NRP*RW-1:0] dx_rs,
  input  logic [NRP-1:0]    dx_rvalid,
  input  logic [RW-1:0]     dx_rd,
  input  logic              dx_we,
  input  logic              dx_md_start,
  input  logic              flush,
  input  logic [RW-1:0]     xm_rd,
  input  logic [RW-1:0]     mw_rd,
  input  logic              xm_we,
  input  logic              mw_we,
  input  logic              xm_is_load,
  output logic [NRP*2-1:0]  fwd_sel,
  output logic              stall,
  output logic              md_busy,
  output logic              md_wb,
  output logic [RW-1:0]     md_dst,
  output logic [CNT_W-1:0]  stall_cnt
);
  localparam int CW = $clog2(MD_LAT + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(MD_LAT - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, WB = 2'd2} state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  md_cnt;
  logic [NRP-1:0] xm_hit, mw_hit, md_hit;
  logic           load_use, sb_stall, struct_stall, wb_stall, md_accept;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Register 0 and unused read ports never match anything.
  for (genvar i = 0; i < NRP; i++) begin : g_port
    logic [RW-1:0] rs;
    logic          rd_live;
    assign rs                = dx_rs[i*RW +: RW];
    assign rd_live           = dx_rvalid[i] && (rs != '0);
    assign xm_hit[i]         = rd_live && xm_we && (rs == xm_rd);
    assign mw_hit[i]         = rd_live && mw_we && (rs == mw_rd);
    assign md_hit[i]         = rd_live && (rs == md_dst);
    assign fwd_sel[i*2 +: 2] = xm_hit[i] ? 2'b00 : (mw_hit[i] ? 2'b01 : 2'b10);
  end

  assign load_use     = xm_is_load && (|xm_hit);
  assign sb_stall     = md_busy && (md_dst != '0) &&
                        ((|md_hit) || (dx_we && (dx_rd == md_dst)));
  assign struct_stall = md_busy && dx_md_start;
  assign wb_stall     = md_wb && mw_we;
  assign stall        = !flush && (load_use || sb_stall || struct_stall || wb_stall);
  assign md_accept    = (state == IDLE) && dx_md_start && !flush && !stall;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      md_cnt    <= '0;
      md_dst    <= '0;
      stall_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (stall) stall_cnt <= sat_inc(stall_cnt);
      if (md_accept) begin
        md_dst <= dx_rd;
        md_cnt <= CNT_LOAD;
      end else if ((state == BUSY) && (md_cnt != '0)) begin
        md_cnt <= md_cnt - CW'(1);
      end
    end
  end

  // BUSY spans MD_LAT cycles: the counter is loaded with MD_LAT-1 and exits at 0.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (md_accept) state_nxt = BUSY;
      BUSY:    if (md_cnt == '0) state_nxt = WB;
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    md_busy = (state == BUSY) || (state == WB);
    md_wb   = (state == WB);
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed vector table, multdiv corner
// sequences, and randomized traffic against a cycle-count reference model.
module tb_hazard_ctrl;
  localparam int NRP = 3, RW = 5, MD_LAT = 4;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [14:0] dx_rs;
  logic [2:0]  dx_rvalid;
  logic [4:0]  dx_rd, xm_rd, mw_rd;
  logic        dx_we, dx_md_start, flush, xm_we, mw_we, xm_is_load;
  logic [5:0]  fwd_sel, fwd_sel2;
  logic        stall, stall2, md_busy, md_busy2, md_wb, md_wb2;
  logic [4:0]  md_dst, md_dst2;
  logic [15:0] stall_cnt;
  logic [1:0]  stall_cnt2;

  int n_chk = 0, n_fail = 0;

  // Reference model: remaining multdiv cycles (BUSY + WB), destination, counters.
  int         m_left, m_cnt, m_cnt2;
  logic [4:0] m_dst;

  always #5 clock = ~clock;

  hazard_ctrl #(.NRP(NRP), .RW(RW), .MD_LAT(MD_LAT), .CNT_W(16)) dut (
    .clock(clock), .reset_n(reset_n), .dx_rs(dx_rs), .dx_rvalid(dx_rvalid),
    .dx_rd(dx_rd), .dx_we(dx_we), .dx_md_start(dx_md_start), .flush(flush),
    .xm_rd(xm_rd), .mw_rd(mw_rd), .xm_we(xm_we), .mw_we(mw_we),
    .xm_is_load(xm_is_load), .fwd_sel(fwd_sel), .stall(stall),
    .md_busy(md_busy), .md_wb(md_wb), .md_dst(md_dst), .stall_cnt(stall_cnt));

  hazard_ctrl #(.NRP(NRP), .RW(RW), .MD_LAT(MD_LAT), .CNT_W(2)) dut2 (
    .clock(clock), .reset_n(reset_n), .dx_rs(dx_rs), .dx_rvalid(dx_rvalid),
    .dx_rd(dx_rd), .dx_we(dx_we), .dx_md_start(dx_md_start), .flush(flush),
    .xm_rd(xm_rd), .mw_rd(mw_rd), .xm_we(xm_we), .mw_we(mw_we),
    .xm_is_load(xm_is_load), .fwd_sel(fwd_sel2), .stall(stall2),
    .md_busy(md_busy2), .md_wb(md_wb2), .md_dst(md_dst2), .stall_cnt(stall_cnt2));

  typedef struct {
    string      name;
    logic [14:0] rs;
    logic [2:0]  rv;
    logic [4:0]  xrd, mrd;
    logic        xwe, mwe, ld, fl;
    logic [5:0]  efs;
    logic        est;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_comb(output logic [5:0] efs, output logic est);
    logic [4:0] rs;
    logic       live, xmh, mwh;
    bit         busy, wb;
    est  = 1'b0;
    efs  = '0;
    busy = (m_left > 0);
    wb   = (m_left == 1);
    for (int i = 0; i < NRP; i++) begin
      rs   = dx_rs[i*RW +: RW];
      live = dx_rvalid[i] && (rs != 5'd0);
      xmh  = live && xm_we && (rs == xm_rd);
      mwh  = live && mw_we && (rs == mw_rd);
      efs[i*2 +: 2] = xmh ? 2'd0 : (mwh ? 2'd1 : 2'd2);
      if (xmh && xm_is_load) est = 1'b1;
      if (busy && m_dst != 5'd0 && live && rs == m_dst) est = 1'b1;
    end
    if (busy && m_dst != 5'd0 && dx_we && dx_rd == m_dst) est = 1'b1;
    if (busy && dx_md_start) est = 1'b1;
    if (wb && mw_we) est = 1'b1;
    if (flush) est = 1'b0;
  endfunction

  task automatic model_reset();
    m_left = 0; m_cnt = 0; m_cnt2 = 0; m_dst = 5'd0;
  endtask

  task automatic model_edge(input logic est);
    if (!reset_n) begin
      model_reset();
    end else begin
      if (est) begin
        m_cnt  = (m_cnt < 65535) ? m_cnt + 1 : m_cnt;
        m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : m_cnt2;
      end
      if (m_left > 0) m_left--;
      else if (dx_md_start && !flush && !est) begin
        m_left = MD_LAT + 1;
        m_dst  = dx_rd;
      end
    end
  endtask

  task automatic step();
    logic [5:0] efs;
    logic       est;
    @(negedge clock);
    model_comb(efs, est);
    chk("fwd_sel",    32'(fwd_sel),    32'(efs));
    chk("stall",      32'(stall),      32'(est));
    chk("md_busy",    32'(md_busy),    32'(m_left > 0));
    chk("md_wb",      32'(md_wb),      32'(m_left == 1));
    chk("md_dst",     32'(md_dst),     32'(m_dst));
    chk("stall_cnt",  32'(stall_cnt),  32'(m_cnt));
    chk("fwd_sel_b",  32'(fwd_sel2),   32'(efs));
    chk("stall_b",    32'(stall2),     32'(est));
    chk("md_busy_b",  32'(md_busy2),   32'(m_left > 0));
    chk("md_wb_b",    32'(md_wb2),     32'(m_left == 1));
    chk("md_dst_b",   32'(md_dst2),    32'(m_dst));
    chk("stall_cnt2", 32'(stall_cnt2), 32'(m_cnt2));
    @(posedge clock);
    model_edge(est);
    #1;
  endtask

  task automatic set_idle();
    dx_rs = '0; dx_rvalid = '0; dx_rd = '0; dx_we = 0; dx_md_start = 0; flush = 0;
    xm_rd = '0; mw_rd = '0; xm_we = 0; mw_we = 0; xm_is_load = 0;
  endtask

  task automatic set_load_use();
    set_idle();
    dx_rs = {5'd0, 5'd7, 5'd0}; dx_rvalid = 3'b010; xm_rd = 5'd7; xm_we = 1; xm_is_load = 1;
  endtask

  initial begin
    vecs[0] = '{"fwd_xm",     {5'd0, 5'd0, 5'd5}, 3'b001, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 6'b101000, 1'b0};
    vecs[1] = '{"fwd_mw",     {5'd0, 5'd0, 5'd5}, 3'b001, 5'd5, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, 6'b101001, 1'b0};
    vecs[2] = '{"rs_zero",    {5'd0, 5'd0, 5'd0}, 3'b001, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 6'b101010, 1'b0};
    vecs[3] = '{"rvalid_off", {5'd0, 5'd0, 5'd5}, 3'b000, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 6'b101010, 1'b0};
    vecs[4] = '{"load_use",   {5'd0, 5'd7, 5'd0}, 3'b010, 5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 6'b100010, 1'b1};
    vecs[5] = '{"load_flush", {5'd0, 5'd7, 5'd0}, 3'b010, 5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 6'b100010, 1'b0};
    vecs[6] = '{"multi_port", {5'd3, 5'd4, 5'd3}, 3'b111, 5'd3, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 6'b000100, 1'b0};
    vecs[7] = '{"load_p2",    {5'd9, 5'd0, 5'd0}, 3'b100, 5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 6'b001010, 1'b1};

    // Reset state
    set_idle();
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("rst_busy", 32'(md_busy), 32'd0);
    chk("rst_wb",   32'(md_wb),   32'd0);
    chk("rst_dst",  32'(md_dst),  32'd0);
    chk("rst_cnt",  32'(stall_cnt), 32'd0);
    step();
    reset_n = 1'b1;
    step();

    // Directed vector table
    for (int k = 0; k < 8; k++) begin
      set_idle();
      dx_rs = vecs[k].rs; dx_rvalid = vecs[k].rv; xm_rd = vecs[k].xrd; mw_rd = vecs[k].mrd;
      xm_we = vecs[k].xwe; mw_we = vecs[k].mwe; xm_is_load = vecs[k].ld; flush = vecs[k].fl;
      #1;
      chk(vecs[k].name, 32'(fwd_sel), 32'(vecs[k].efs));
      chk(vecs[k].name, 32'(stall),   32'(vecs[k].est));
      step();
    end

    // Load-use stall counts once per cycle
    begin
      int c0;
      c0 = m_cnt;
      set_load_use();
      repeat (3) step();
      chk("cnt_plus3", 32'(stall_cnt), 32'(c0 + 3));
    end

    // Multdiv: 5 busy cycles, RAW and WAW stalls, writeback in the last one
    set_idle(); dx_md_start = 1; dx_rd = 5'd9; dx_we = 1; #1;
    chk("md_start_nostall", 32'(stall), 32'd0);
    step();
    for (int k = 0; k < 5; k++) begin
      set_idle();
      if (k % 2 == 0) begin dx_rs = 15'd9; dx_rvalid = 3'b001; end
      else begin dx_rd = 5'd9; dx_we = 1; end
      #1;
      chk("md_busy_seq", 32'(md_busy), 32'd1);
      chk("md_wb_seq",   32'(md_wb),   32'(k == 4));
      chk((k % 2 == 0) ? "raw_stall" : "waw_stall", 32'(stall), 32'd1);
      step();
    end
    set_idle(); #1;
    chk("md_done",     32'(md_busy), 32'd0);
    chk("md_dst_hold", 32'(md_dst),  32'd9);
    step();

    // Back-to-back start: structural stall until after WB, then accepted
    set_idle(); dx_md_start = 1; dx_rd = 5'd12; step();
    for (int k = 0; k < 5; k++) begin
      set_idle(); dx_md_start = 1; dx_rd = 5'd13; mw_we = 1; mw_rd = 5'd20; #1;
      chk("struct_stall", 32'(stall), 32'd1);
      step();
    end
    set_idle(); dx_md_start = 1; dx_rd = 5'd13; mw_we = 1; mw_rd = 5'd20; #1;
    chk("restart_ok",   32'(stall),   32'd0);
    chk("restart_idle", 32'(md_busy), 32'd0);
    step();
    set_idle(); #1;
    chk("md_dst_new", 32'(md_dst),  32'd13);
    chk("busy_again", 32'(md_busy), 32'd1);
    for (int k = 0; k < 5; k++) begin
      set_idle(); mw_we = 1; mw_rd = 5'd20; #1;
      chk("wb_port_stall", 32'(stall), 32'(k == 4));
      step();
    end

    // Asynchronous reset in BUSY cycle 2 abandons the operation
    set_idle(); dx_md_start = 1; dx_rd = 5'd6; step();
    set_idle(); step();
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("rst_mid_busy", 32'(md_busy), 32'd0);
    chk("rst_mid_wb",   32'(md_wb),   32'd0);
    chk("rst_mid_dst",  32'(md_dst),  32'd0);
    step();
    reset_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      set_idle(); #1;
      chk("no_wb_after_reset", 32'(md_wb), 32'd0);
      step();
    end

    // Counter saturation on the narrow instance
    set_load_use();
    repeat (6) step();
    set_idle(); #1;
    chk("cnt16_six", 32'(stall_cnt),  32'd6);
    chk("cnt2_sat",  32'(stall_cnt2), 32'd3);
    step();

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      dx_rs       = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      dx_rvalid   = 3'($urandom);
      dx_rd       = 5'($urandom_range(0, 3));
      dx_we       = 1'($urandom);
      dx_md_start = ($urandom_range(0, 5) == 0);
      flush       = ($urandom_range(0, 7) == 0);
      xm_rd       = 5'($urandom_range(0, 3));
      mw_rd       = 5'($urandom_range(0, 3));
      xm_we       = 1'($urandom);
      mw_we       = 1'($urandom);
      xm_is_load  = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 149) == 0) begin
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("rnd_rst_busy", 32'(md_busy), 32'd0);
        reset_n = 1'b1;
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter NRP, default 3: number of DX-stage register read ports (ALU A, ALU B, store-data/jr).
REQ-002 Parameter RW, default 5: register index width.
REQ-003 Parameter MD_LAT, default 32: multdiv execute cycles; the legal range SHALL be MD_LAT >= 1.
REQ-004 Parameter CNT_W, default 16: stall performance counter width.
REQ-005 Ports SHALL be, one per line:
- clock  in  1  single clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- dx_rs  in  NRP*RW  DX source register of port i at bits [i*RW +: RW]
- dx_rvalid  in  NRP  port i actually reads a register
- dx_rd  in  RW  DX destination register
- dx_we  in  1  DX writes dx_rd
- dx_md_start  in  1  DX instruction is mult/div
- flush  in  1  branch/jump taken; kills the DX instruction
- xm_rd, mw_rd  in  RW each  XM/MW destination registers
- xm_we, mw_we  in  1 each  XM/MW register write enables
- xm_is_load  in  1  XM instruction is a load
- fwd_sel  out  NRP*2  per-port operand source, [i*2 +: 2]: 00 = XM, 01 = MW, 10 = regfile
- stall  out  1  hold PC, FD and DX; insert a bubble into XM
- md_busy  out  1  multdiv in flight (state BUSY or WB)
- md_wb  out  1  one-cycle multdiv writeback slot; the pipeline SHALL write md_dst this cycle
- md_dst  out  RW  destination of the in-flight multdiv
- stall_cnt  out  CNT_W  saturating count of stalled cycles

Function
REQ-006 Per port i, a match SHALL require dx_rvalid[i] = 1 and dx_rs_i != 0; register 0 never forwards or stalls.
REQ-007 fwd_sel_i SHALL be 00 if dx_rs_i == xm_rd and xm_we = 1; else 01 if dx_rs_i == mw_rd and mw_we = 1; else 10. XM has priority over MW. fwd_sel is combinational.
REQ-008 Load-use: an XM match on any port while xm_is_load = 1 SHALL assert stall. fwd_sel still follows REQ-007.
REQ-009 The FSM SHALL have the states IDLE, BUSY and WB, with a down-counter of ceil(log2(MD_LAT+1)) bits.
REQ-010 IDLE->BUSY SHALL occur when dx_md_start = 1, flush = 0 and stall = 0. On that edge md_dst <= dx_rd and the counter <= MD_LAT-1.
REQ-011 In BUSY the counter SHALL decrement each cycle; at counter = 0 the FSM SHALL go to WB on the next edge. BUSY therefore lasts exactly MD_LAT cycles.
REQ-012 WB SHALL last exactly 1 cycle with md_wb = 1, then return to IDLE. md_dst SHALL hold its value until the next accepted start.
REQ-013 Scoreboard stall: while md_busy = 1 and md_dst != 0, stall SHALL assert if any port matches md_dst (RAW), or if dx_we = 1 and dx_rd == md_dst (WAW).
REQ-014 Structural stall: dx_md_start = 1 while md_busy = 1 SHALL assert stall.
REQ-015 Writeback conflict: in WB, stall SHALL assert if mw_we = 1, so that md_wb owns the write port.
REQ-016 stall SHALL be the OR of REQ-008 and REQ-013..015, and SHALL be forced to 0 when flush = 1.
REQ-017 Flush SHALL NOT abort an in-flight multdiv. A flushed dx_md_start SHALL NOT start the FSM.
REQ-018 stall_cnt SHALL increment on each edge where stall = 1 and SHALL saturate at all-ones.
REQ-019 If md_dst = 0, the FSM SHALL still run its full latency, with no scoreboard stalls and md_wb still pulsed.

Reset
REQ-020 When reset_n = 0, asynchronously: state = IDLE, counter = 0, md_dst = 0, stall_cnt = 0, md_busy = 0, md_wb = 0.
REQ-021 Reset mid-BUSY or mid-WB SHALL abandon the operation; no md_wb pulse follows.
REQ-022 fwd_sel and the load-use and flush terms of stall SHALL remain combinational during reset.

Verification
REQ-023 dx_rs0 = 5, xm_rd = 5, xm_we = 1, mw_rd = 5, mw_we = 1 -> fwd_sel0 = 00. With xm_we = 0 -> 01. With dx_rs0 = 0 -> 10 and stall = 0.
REQ-024 xm_is_load = 1, xm_rd = 7, dx_rs1 = 7, dx_rvalid[1] = 1 -> stall = 1 and stall_cnt +1 per cycle. Adding flush = 1 -> stall = 0.
REQ-025 MD_LAT = 4, start with dx_rd = 9 -> md_busy = 1 for 5 cycles, md_wb high only in the 5th. dx_rs0 = 9 stalls throughout; dx_rd = 9 with dx_we = 1 stalls (WAW).
REQ-026 Second dx_md_start during BUSY -> stall until the cycle after WB, then the start is accepted. In WB with mw_we = 1 -> stall = 1.
REQ-027 reset_n pulled low in BUSY cycle 2 -> md_busy = 0 and md_wb = 0 immediately, with no later md_wb pulse. CNT_W = 2 with stall held 6 cycles -> stall_cnt = 3.
